vac_divider_gen: RTL and testbench

Multi-channel digital AC stimulus source for mixed-signal transient benches: each channel is a phase-accumulator sine generator (frequency, phase) followed by a programmable resistive-divider attenuation (ratio R2/(R1+R2) expressed as a fixed-point gain). It replaces fixed single-source, fixed-ratio divider stimulus with run-time-configurable, parallel channels feeding DAC models or downstream digital checkers over a valid/ready output stream.

---
 rtl/vac_divider_gen.sv | 194 +++++++++++++++++++
 tb/tb_vac_divider_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vac_divider_gen.sv
// vac_divider_gen: multi-channel phase-accumulator sine source. Each channel is
// scaled by a fixed-point divider gain and streamed out through a valid/ready register.
module vac_divider_gen #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 24,
    parameter int LUT_AW   = 8,
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [1:0]                   cfg_sel,
    input  logic [PHASE_W-1:0]           cfg_data,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         sample_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*SAMPLE_W-1:0] out_data,
    output logic                         busy,
    output logic                         overrun
);
    localparam int QTR    = 2 ** (LUT_AW - 2);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    typedef enum logic [1:0] { IDLE, RUN, DRAIN } state_t;
    state_t state_q, state_d;

    logic [PHASE_W-1:0]           freq_r  [CHANNELS];
    logic [PHASE_W-1:0]           phase_r [CHANNELS];
    logic [GAIN_W-1:0]            gain_r  [CHANNELS];
    logic [PHASE_W-1:0]           acc_r   [CHANNELS];

    logic                         vld_p0, vld_p1;
    logic [LUT_AW-1:0]            idx_p0  [CHANNELS];
    logic signed [SAMPLE_W-1:0]   samp_p1 [CHANNELS];
    logic [CHANNELS*SAMPLE_W-1:0] set_p2;

    logic launch, load_acc, pipe_empty;

    // First quadrant (0..pi/2 inclusive) of round(32767*sin(2*pi*k/256)); the
    // stored values are sized for the default LUT_AW=8 / SAMPLE_W=16 build.
    function automatic int quarter_sin(input int k);
        int v;
        case (k)
            0:  v = 0;     1:  v = 804;   2:  v = 1608;  3:  v = 2410;
            4:  v = 3212;  5:  v = 4011;  6:  v = 4808;  7:  v = 5602;
            8:  v = 6393;  9:  v = 7179;  10: v = 7962;  11: v = 8739;
            12: v = 9512;  13: v = 10278; 14: v = 11039; 15: v = 11793;
            16: v = 12539; 17: v = 13279; 18: v = 14010; 19: v = 14732;
            20: v = 15446; 21: v = 16151; 22: v = 16846; 23: v = 17530;
            24: v = 18204; 25: v = 18868; 26: v = 19519; 27: v = 20159;
            28: v = 20787; 29: v = 21403; 30: v = 22005; 31: v = 22594;
            32: v = 23170; 33: v = 23731; 34: v = 24279; 35: v = 24811;
            36: v = 25329; 37: v = 25832; 38: v = 26319; 39: v = 26790;
            40: v = 27245; 41: v = 27683; 42: v = 28105; 43: v = 28510;
            44: v = 28898; 45: v = 29268; 46: v = 29621; 47: v = 29956;
            48: v = 30273; 49: v = 30571; 50: v = 30852; 51: v = 31113;
            52: v = 31356; 53: v = 31580; 54: v = 31785; 55: v = 31971;
            56: v = 32137; 57: v = 32285; 58: v = 32412; 59: v = 32521;
            60: v = 32609; 61: v = 32678; 62: v = 32728; 63: v = 32757;
            64: v = 32767;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Quadrant 1/3 mirror the offset, quadrants 2/3 negate the magnitude.
    function automatic logic signed [SAMPLE_W-1:0] sine_lookup(input logic [LUT_AW-1:0] idx);
        logic [LUT_AW-3:0]          off;
        int                         k;
        logic signed [SAMPLE_W-1:0] mag;
        off = idx[LUT_AW-3:0];
        k   = idx[LUT_AW-2] ? (QTR - int'(off)) : int'(off);
        mag = SAMPLE_W'(quarter_sin(k));
        return idx[LUT_AW-1] ? -mag : mag;
    endfunction

    // Divider ratio gain/2^GAIN_W: full-precision product, floor via arithmetic shift.
    function automatic logic signed [SAMPLE_W-1:0] div_scale(
        input logic signed [SAMPLE_W-1:0] s,
        input logic [GAIN_W-1:0]          g
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(s) * $signed(PROD_W'(g));
        return prod[GAIN_W +: SAMPLE_W];
    endfunction

    assign pipe_empty = !vld_p0 && !vld_p1;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        load_acc = 1'b0;
        case (state_q)
            IDLE: begin
                load_acc = start;
                if (start) state_d = RUN;
            end
            RUN: begin
                launch = sample_en;
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                freq_r[c]  <= '0;
                phase_r[c] <= '0;
                gain_r[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_we && (cfg_ch == CH_W'(c))) begin
                    case (cfg_sel)
                        2'd0:    freq_r[c]  <= cfg_data;
                        2'd1:    phase_r[c] <= cfg_data;
                        2'd2:    gain_r[c]  <= cfg_data[GAIN_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) acc_r[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load_acc)    acc_r[c] <= phase_r[c];
                else if (launch) acc_r[c] <= acc_r[c] + freq_r[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= launch;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: index capture; stage p1: table read
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (launch) idx_p0[c]  <= acc_r[c][PHASE_W-1 -: LUT_AW];
            if (vld_p0) samp_p1[c] <= sine_lookup(idx_p0[c]);
        end
    end

    // Stage p2: divider multiply feeding the output register
    always_comb begin
        set_p2 = '0;
        for (int c = 0; c < CHANNELS; c++)
            set_p2[c*SAMPLE_W +: SAMPLE_W] = div_scale(samp_p1[c], gain_r[c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load_acc) overrun <= 1'b0;
            if (vld_p1) begin
                out_valid <= 1'b1;
                out_data  <= set_p2;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vac_divider_gen.sv
// Directed bench for vac_divider_gen: reset, tone/phase, backpressure, drain, wrap, mid-run reset.
module tb_vac_divider_gen;
    localparam int CH = 2;
    localparam int PW = 24;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [0:0]    cfg_ch;
    logic [1:0]    cfg_sel;
    logic [PW-1:0] cfg_data;
    logic          start, stop, sample_en;
    logic          out_valid, out_ready;
    logic [CH*SW-1:0] out_data;
    logic          busy, overrun;

    int n_cmp;
    int n_err;
    logic [PW-1:0] m0, m1;

    always #5 clk = ~clk;

    vac_divider_gen #(.CHANNELS(CH), .PHASE_W(PW), .LUT_AW(8), .SAMPLE_W(SW), .GAIN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .start(start), .stop(stop), .sample_en(sample_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] chan(input int c);
        return 64'($signed(out_data[c*SW +: SW]));
    endfunction

    // Reference: rounded 32767*sin table entry, then floor(s*gain/65536).
    function automatic logic signed [63:0] model(input int idx, input int gain);
        real    v;
        longint s, p;
        v = 32767.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
        s = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
        p = s * longint'(gain);
        return 64'(p >>> 16);
    endfunction

    task automatic cfg(input int c, input int sel, input logic [PW-1:0] d);
        cfg_we = 1'b1; cfg_ch = 1'(c); cfg_sel = 2'(sel); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; sample_en = 1'b0; out_ready = 1'b1;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            start = i[0]; stop = ~i[0]; sample_en = 1'b1; cfg_we = 1'b1;
            cfg_sel = 2'(i); cfg_data = 24'hABCDEF; out_ready = i[1];
            tick();
        end
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_data", 64'(out_data), 64'd0);
        sample_en = 1'b0;

        // Single tone on ch0, quarter-period phase offset on ch1
        cfg(0, 0, 24'h010000); cfg(0, 1, 24'h000000); cfg(0, 2, 24'h008000);
        cfg(1, 0, 24'h010000); cfg(1, 1, 24'h400000); cfg(1, 2, 24'h008000);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        sample_en = 1'b1;
        tick();
        chk("lat1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat2_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat3_valid", 64'(out_valid), 64'd1);
        chk("first_ch0", chan(0), 64'sd0);
        chk("first_ch1", chan(1), 64'sd16383);
        for (int n = 1; n < 260; n++) begin
            tick();
            chk("tone_valid", 64'(out_valid), 64'd1);
            chk("tone_ch0", chan(0), model(n % 256, 32768));
            chk("tone_ch1", chan(1), model((n + 64) % 256, 32768));
            if (n == 64)  chk("ch0_peak", chan(0), 64'sd16383);
            if (n == 192) chk("ch0_trough", chan(0), -64'sd16384);
            if (n == 256) chk("ch0_period", chan(0), 64'sd0);
        end

        // Stop one cycle after the last sample_en; start in DRAIN ignored
        tick();
        chk("pre_stop_ch0", chan(0), model(4, 32768));
        sample_en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0; start = 1'b1; sample_en = 1'b1;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_ch0_a", chan(0), model(5, 32768));
        tick();
        start = 1'b0;
        chk("drain_busy2", 64'(busy), 64'd1);
        chk("drain_ch0_b", chan(0), model(6, 32768));
        chk("drain_ch1_b", chan(1), model(70, 32768));
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        tick(); tick();
        chk("idle_ign_busy", 64'(busy), 64'd0);
        chk("idle_ign_valid", 64'(out_valid), 64'd0);
        sample_en = 1'b0;

        // Backpressure with ch1 gain 0
        cfg(1, 2, 24'h000000);
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b0; sample_en = 1'b1;
        tick(); tick();
        sample_en = 1'b0;
        tick();
        chk("bp1_valid", 64'(out_valid), 64'd1);
        chk("bp1_overrun", 64'(overrun), 64'd0);
        chk("bp1_ch0", chan(0), 64'sd0);
        chk("bp1_ch1_gain0", chan(1), 64'sd0);
        tick();
        chk("bp2_overrun", 64'(overrun), 64'd1);
        chk("bp2_ch0_newer", chan(0), 64'sd402);
        chk("bp2_ch1_gain0", chan(1), 64'sd0);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        chk("held_busy", 64'(busy), 64'd0);
        chk("held_valid", 64'(out_valid), 64'd1);
        chk("held_overrun", 64'(overrun), 64'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_clr_overrun", 64'(overrun), 64'd0);
        chk("start_keep_valid", 64'(out_valid), 64'd1);
        sample_en = 1'b1; tick(); sample_en = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        chk("same_cyc_valid", 64'(out_valid), 64'd1);
        chk("same_cyc_overrun", 64'(overrun), 64'd0);
        chk("same_cyc_ch0", chan(0), 64'sd0);
        tick();
        chk("consumed_valid", 64'(out_valid), 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();

        // Accumulator wrap: ch0 steps by -1 LSB, ch1 by an odd increment
        cfg(0, 0, 24'hFFFFFF);
        cfg(1, 0, 24'h012345);
        cfg(1, 2, 24'h004000);
        m0 = 24'h000000; m1 = 24'h400000;
        start = 1'b1; tick(); start = 1'b0;
        sample_en = 1'b1;
        tick(); tick();
        for (int k = 0; k < 1000; k++) begin
            tick();
            chk("wrap_ch0", chan(0), model(int'(m0[23:16]), 32768));
            chk("wrap_ch1", chan(1), model(int'(m1[23:16]), 16384));
            m0 = m0 + 24'hFFFFFF;
            m1 = m1 + 24'h012345;
        end

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("arst_after_valid", 64'(out_valid), 64'd0);
        chk("arst_after_busy", 64'(busy), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("cleared_cfg_valid", 64'(out_valid), 64'd1);
        chk("cleared_cfg_ch0", chan(0), 64'sd0);
        chk("cleared_cfg_ch1", chan(1), 64'sd0);
        sample_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
